// File: rtl/uart_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// uart_ctrl_pkg
// Shared types and constants for the UART transmit arbiter slice.
//   arb_state_t      : arbiter FSM states (IDLE, SEND, WAIT, GAP)
//   UART_ARB_MAX_REQ : largest supported requester count
//   GRANT_W          : width of a requester index
//   GAP_W / WDOG_W   : widths of the inter-byte gap and watchdog counters
// ---------------------------------------------------------------------------
package uart_ctrl_pkg;

  localparam int UART_ARB_MAX_REQ = 8;
  localparam int GRANT_W          = $clog2(UART_ARB_MAX_REQ);
  localparam int GAP_W            = 16;
  // One bit wider than the largest timeout so the compare never wraps.
  localparam int WDOG_W           = 17;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_WAIT = 2'd2,
    ST_GAP  = 2'd3
  } arb_state_t;

endpackage

// File: rtl/uart_rr_pick.sv
// ---------------------------------------------------------------------------
// uart_rr_pick
// Combinational round-robin picker. Scans upward from (last_idx+1) mod N_REQ,
// wrapping, and returns the first set request.
//   req      in  N_REQ   : request vector
//   last_idx in  GRANT_W : index granted most recently
//   gnt      out N_REQ   : one-hot grant (zero when no request)
//   idx      out GRANT_W : index of the granted request (last_idx when none)
//   any      out 1       : at least one request is set
// ---------------------------------------------------------------------------
module uart_rr_pick
  import uart_ctrl_pkg::*;
#(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0]   req,
  input  logic [GRANT_W-1:0] last_idx,
  output logic [N_REQ-1:0]   gnt,
  output logic [GRANT_W-1:0] idx,
  output logic               any
);

  // NOTE: every output of a combinational block gets a default before any
  // conditional assignment; a path that skips an assignment infers a latch.
  always_comb begin
    int j;
    gnt = '0;
    idx = last_idx;
    any = 1'b0;
    j   = 0;
    // Offset N_REQ lands back on last_idx, so it has the lowest priority.
    for (int off = 1; off <= N_REQ; off++) begin
      j = int'(last_idx) + off;
      if (j >= N_REQ) j = j - N_REQ;
      if (!any && req[j]) begin
        any    = 1'b1;
        gnt[j] = 1'b1;
        idx    = GRANT_W'(j);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter
// Round-robin scheduler sharing one 8N1 byte transmitter among N_REQ byte
// producers. Accepts one byte from the winner over valid/ready, pulses tx_go
// with the byte, waits for tx_done (guarded by a watchdog), idles for
// GAP_CYCLES, then re-arbitrates.
//
// Parameters: N_REQ (2..8), GAP_CYCLES (0..65535), TIMEOUT_CYCLES (0 = off)
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   req_valid [N]   : requester i holds a byte
//   req_data  [8N]  : byte of requester i at [8i+7:8i]
//   req_last  [N]   : end-of-packet marker (UART_ARB_PKT_LOCK_EN only)
//   req_ready [N]   : one-hot accept, combinational in IDLE only
//   tx_go           : one-cycle start pulse to the transmitter
//   tx_data   [8]   : byte for the transmitter, held until the next accept
//   tx_done         : one-cycle pulse from the transmitter after stop bit
//   busy            : FSM is not in IDLE
//   grant_id  [3]   : index of the last accepted requester
//   err_timeout     : one-cycle pulse when the watchdog fires
//
// Build option: define UART_ARB_PKT_LOCK_EN to hold the grant on one
// requester until it presents a byte with req_last set.
// ---------------------------------------------------------------------------
module uart_tx_arbiter
  import uart_ctrl_pkg::*;
#(
  parameter int N_REQ          = 4,
  parameter int GAP_CYCLES     = 0,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [8*N_REQ-1:0]   req_data,
`ifdef UART_ARB_PKT_LOCK_EN
  input  logic [N_REQ-1:0]     req_last,
`endif
  output logic [N_REQ-1:0]     req_ready,
  output logic                 tx_go,
  output logic [7:0]           tx_data,
  input  logic                 tx_done,
  output logic                 busy,
  output logic [GRANT_W-1:0]   grant_id,
  output logic                 err_timeout
);

  localparam logic [GAP_W-1:0]  GAP_END  = GAP_W'(GAP_CYCLES - 1);
  localparam logic [WDOG_W-1:0] WDOG_END = WDOG_W'(TIMEOUT_CYCLES);

  arb_state_t          state_q, state_d;
  logic [7:0]          tx_data_q;
  logic [GRANT_W-1:0]  grant_id_q;
  logic [GAP_W-1:0]    gap_cnt_q;
  logic [WDOG_W-1:0]   wdog_cnt_q;
  logic [WDOG_W-1:0]   wdog_inc;
  logic                err_q;

  logic [N_REQ-1:0]    pick_gnt;
  logic [GRANT_W-1:0]  pick_idx;
  logic                pick_any;
  logic [N_REQ-1:0]    sel_gnt;
  logic [GRANT_W-1:0]  sel_idx;
  logic                sel_any;
  logic [7:0]          sel_byte;
  logic                accept;
  logic                wdog_hit;
  logic                timeout_fire;

  uart_rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req      (req_valid),
    .last_idx (grant_id_q),
    .gnt      (pick_gnt),
    .idx      (pick_idx),
    .any      (pick_any)
  );

`ifdef UART_ARB_PKT_LOCK_EN
  logic lock_q;

  // While locked only the current owner may be granted; others wait.
  always_comb begin
    sel_gnt = pick_gnt;
    sel_idx = pick_idx;
    sel_any = pick_any;
    if (lock_q) begin
      sel_any = req_valid[grant_id_q];
      sel_gnt = sel_any ? (N_REQ'(1) << grant_id_q) : '0;
      sel_idx = grant_id_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_q <= 1'b0;
    end else if (accept) begin
      lock_q <= !req_last[sel_idx];
    end else if (timeout_fire) begin
      lock_q <= 1'b0;
    end
  end
`else
  assign sel_gnt = pick_gnt;
  assign sel_idx = pick_idx;
  assign sel_any = pick_any;
`endif

  // One-hot OR mux of the winning byte.
  always_comb begin
    sel_byte = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (sel_gnt[i]) sel_byte = req_data[8*i +: 8];
    end
  end

  assign accept       = (state_q == ST_IDLE) && sel_any;
  assign wdog_inc     = wdog_cnt_q + WDOG_W'(1);
  assign wdog_hit     = (TIMEOUT_CYCLES != 0) && (wdog_inc == WDOG_END);
  assign timeout_fire = (state_q == ST_WAIT) && !tx_done && wdog_hit;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (accept) state_d = ST_SEND;
      ST_SEND: state_d = ST_WAIT;
      ST_WAIT: begin
        if (tx_done)           state_d = (GAP_CYCLES > 0) ? ST_GAP : ST_IDLE;
        else if (timeout_fire) state_d = ST_IDLE;
      end
      ST_GAP:  if (gap_cnt_q == GAP_END) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: reset is asynchronous, so it appears in the sensitivity list and
  // every register returns to its reset value without waiting for clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      tx_data_q  <= 8'h00;
      grant_id_q <= GRANT_W'(N_REQ - 1);
      gap_cnt_q  <= '0;
      wdog_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every register sample the
      // pre-edge values, independent of statement order.
      state_q <= state_d;
      err_q   <= timeout_fire;
      if (accept) begin
        tx_data_q  <= sel_byte;
        grant_id_q <= sel_idx;
      end
      if (state_q == ST_SEND) begin
        wdog_cnt_q <= '0;
      end else if (state_q == ST_WAIT && TIMEOUT_CYCLES != 0) begin
        wdog_cnt_q <= wdog_inc;
      end
      if (state_q == ST_WAIT) begin
        gap_cnt_q <= '0;
      end else if (state_q == ST_GAP) begin
        gap_cnt_q <= gap_cnt_q + GAP_W'(1);
      end
    end
  end

  // Ready is gated by reset so it reads zero while rst_n is held low.
  assign req_ready   = (state_q == ST_IDLE && rst_n) ? sel_gnt : '0;
  assign tx_go       = (state_q == ST_SEND);
  assign tx_data     = tx_data_q;
  assign busy        = (state_q != ST_IDLE);
  assign grant_id    = grant_id_q;
  assign err_timeout = err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_arbiter
// Directed bench for uart_tx_arbiter. dut0: N_REQ=4, GAP_CYCLES=0,
// TIMEOUT_CYCLES=20. dut1: N_REQ=4, GAP_CYCLES=10, watchdog off.
// Inputs change on the falling edge; outputs are sampled 1 ns later.
// ---------------------------------------------------------------------------
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  always #5 clk = ~clk;

  localparam logic [31:0] DATA = 32'h44_33_A5_11;

  // dut0
  logic [3:0]  req_valid = '0;
  logic [3:0]  req_ready;
  logic        tx_go, tx_done = 1'b0, busy, err_timeout;
  logic [7:0]  tx_data;
  logic [2:0]  grant_id;
`ifdef UART_ARB_PKT_LOCK_EN
  logic [3:0]  req_last = 4'b1111;
`endif

  // dut1
  logic [3:0]  g_valid = '0;
  logic [3:0]  g_ready;
  logic        g_go, g_done = 1'b0, g_busy, g_err;
  logic [7:0]  g_data;
  logic [2:0]  g_gid;

  uart_tx_arbiter #(.N_REQ(4), .GAP_CYCLES(0), .TIMEOUT_CYCLES(20)) dut0 (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_data    (DATA),
`ifdef UART_ARB_PKT_LOCK_EN
    .req_last    (req_last),
`endif
    .req_ready   (req_ready),
    .tx_go       (tx_go),
    .tx_data     (tx_data),
    .tx_done     (tx_done),
    .busy        (busy),
    .grant_id    (grant_id),
    .err_timeout (err_timeout)
  );

  uart_tx_arbiter #(.N_REQ(4), .GAP_CYCLES(10), .TIMEOUT_CYCLES(0)) dut1 (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (g_valid),
    .req_data    (DATA),
`ifdef UART_ARB_PKT_LOCK_EN
    .req_last    (4'b1111),
`endif
    .req_ready   (g_ready),
    .tx_go       (g_go),
    .tx_data     (g_data),
    .tx_done     (g_done),
    .busy        (g_busy),
    .grant_id    (g_gid),
    .err_timeout (g_err)
  );

  typedef struct {
    logic [3:0] valid;
    logic       done;
    logic [3:0] rdy;
    logic       go;
    logic [7:0] txd;
    logic       busy;
    logic [2:0] gid;
  } vec_t;

  vec_t vecs[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic [3:0] v, input logic d, input logic [3:0] r,
                     input logic g, input logic [7:0] t, input logic b, input logic [2:0] id);
    vec_t e;
    e.valid = v; e.done = d; e.rdy = r; e.go = g; e.txd = t; e.busy = b; e.gid = id;
    vecs.push_back(e);
  endtask

  function automatic logic [31:0] outs0();
    return 32'({req_ready, tx_go, tx_data, busy, grant_id, err_timeout});
  endfunction

  // One complete byte on dut0: accept, SEND, WAIT with tx_done, back to IDLE.
  task automatic send_byte(input string name, input logic [3:0] v, input logic [3:0] last,
                           input logic [3:0] exp_rdy, input logic [2:0] exp_gid,
                           input logic [7:0] exp_txd);
    @(negedge clk);
    req_valid = v;
    tx_done   = 1'b0;
`ifdef UART_ARB_PKT_LOCK_EN
    req_last  = last;
`else
    if (last != last) req_last_unused();
`endif
    #1 check({name, "_ready"}, 32'(req_ready), 32'(exp_rdy));
    @(negedge clk);
    #1 check({name, "_send"}, 32'({tx_go, grant_id, tx_data}), 32'({1'b1, exp_gid, exp_txd}));
    @(negedge clk);
    tx_done = 1'b1;
    @(negedge clk);
    tx_done   = 1'b0;
    req_valid = '0;
  endtask

  function automatic void req_last_unused();
  endfunction

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    int k;

    // reset state, round robin 0,1,2,3,0 with GAP_CYCLES=0
    add(4'b0000, 0, 4'b0000, 0, 8'h00, 0, 3'd3);
    add(4'b1111, 0, 4'b0001, 0, 8'h00, 0, 3'd3);
    add(4'b1111, 0, 4'b0000, 1, 8'h11, 1, 3'd0);
    add(4'b1111, 0, 4'b0000, 0, 8'h11, 1, 3'd0);
    add(4'b1111, 1, 4'b0000, 0, 8'h11, 1, 3'd0);
    add(4'b1111, 0, 4'b0010, 0, 8'h11, 0, 3'd0);
    add(4'b1111, 0, 4'b0000, 1, 8'hA5, 1, 3'd1);
    add(4'b1111, 0, 4'b0000, 0, 8'hA5, 1, 3'd1);
    add(4'b1111, 1, 4'b0000, 0, 8'hA5, 1, 3'd1);
    add(4'b1111, 0, 4'b0100, 0, 8'hA5, 0, 3'd1);
    add(4'b1111, 0, 4'b0000, 1, 8'h33, 1, 3'd2);
    add(4'b1111, 0, 4'b0000, 0, 8'h33, 1, 3'd2);
    add(4'b1111, 1, 4'b0000, 0, 8'h33, 1, 3'd2);
    add(4'b1111, 0, 4'b1000, 0, 8'h33, 0, 3'd2);
    add(4'b1111, 0, 4'b0000, 1, 8'h44, 1, 3'd3);
    add(4'b1111, 0, 4'b0000, 0, 8'h44, 1, 3'd3);
    add(4'b1111, 1, 4'b0000, 0, 8'h44, 1, 3'd3);
    add(4'b1111, 0, 4'b0001, 0, 8'h44, 0, 3'd3);
    add(4'b1111, 0, 4'b0000, 1, 8'h11, 1, 3'd0);
    add(4'b1111, 0, 4'b0000, 0, 8'h11, 1, 3'd0);
    add(4'b1111, 1, 4'b0000, 0, 8'h11, 1, 3'd0);
    // single request on 1; tx_done in SEND and IDLE must be ignored
    add(4'b0010, 0, 4'b0010, 0, 8'h11, 0, 3'd0);
    add(4'b0000, 1, 4'b0000, 1, 8'hA5, 1, 3'd1);
    add(4'b0000, 0, 4'b0000, 0, 8'hA5, 1, 3'd1);
    add(4'b0000, 0, 4'b0000, 0, 8'hA5, 1, 3'd1);
    add(4'b0010, 1, 4'b0000, 0, 8'hA5, 1, 3'd1);
    add(4'b0000, 1, 4'b0000, 0, 8'hA5, 0, 3'd1);
    add(4'b0000, 0, 4'b0000, 0, 8'hA5, 0, 3'd1);

    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      req_valid = vecs[i].valid;
      tx_done   = vecs[i].done;
      #1 check($sformatf("vec%0d", i), outs0(),
               32'({vecs[i].rdy, vecs[i].go, vecs[i].txd, vecs[i].busy, vecs[i].gid, 1'b0}));
    end

    // watchdog: requester 2 granted, tx_done never returned
    @(negedge clk);
    req_valid = 4'b0100;
    tx_done   = 1'b0;
    #1 check("wd_ready", 32'(req_ready), 32'h4);
    @(negedge clk);
    req_valid = 4'b1111;
    #1 check("wd_go", 32'({tx_go, grant_id, tx_data}), 32'({1'b1, 3'd2, 8'h33}));
    k = 0;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      #1;
      if (err_timeout) begin
        k = c;
        break;
      end
    end
    check("wd_latency", 32'(k), 32'd21);
    check("wd_idle_next", 32'({busy, req_ready}), 32'({1'b0, 4'b1000}));
    @(negedge clk);
    #1 check("wd_pulse_end", 32'({err_timeout, tx_go, grant_id}), 32'({1'b0, 1'b1, 3'd3}));
    @(negedge clk);
    tx_done   = 1'b1;
    req_valid = '0;
    @(negedge clk);
    tx_done = 1'b0;

    // reset during WAIT with tx_done pending
    @(negedge clk);
    req_valid = 4'b0001;
    #1 check("rst_pre_ready", 32'(req_ready), 32'h1);
    @(negedge clk);
    req_valid = 4'b1111;
    @(negedge clk);
    tx_done = 1'b1;
    #2 rst_n = 1'b0;
    #1 check("rst_outputs", outs0(), 32'({4'b0000, 1'b0, 8'h00, 1'b0, 3'd3, 1'b0}));
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("rst_first_grant", 32'(req_ready), 32'h1);
    @(negedge clk);
    tx_done = 1'b0;
    #1 check("rst_send", 32'({tx_go, grant_id, tx_data}), 32'({1'b1, 3'd0, 8'h11}));
    @(negedge clk);
    tx_done   = 1'b1;
    req_valid = '0;
    @(negedge clk);
    tx_done = 1'b0;

    // gap of 10 on dut1: next ready no earlier than D+11
    @(negedge clk);
    g_valid = 4'b0001;
    #1 check("gap_ready0", 32'(g_ready), 32'h1);
    @(negedge clk);
    @(negedge clk);
    g_done = 1'b1;
    k = 0;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      g_done = 1'b0;
      #1;
      if (c == 1) check("gap_busy", 32'(g_busy), 32'h1);
      if (g_ready != 4'b0000) begin
        k = c;
        break;
      end
    end
    check("gap_latency", 32'(k), 32'd11);
    @(negedge clk);
    g_valid = '0;

`ifdef UART_ARB_PKT_LOCK_EN
    // packet lock: req 2 sends three bytes, then rotation resumes at 3
    send_byte("lk_a", 4'b0010, 4'b1111, 4'b0010, 3'd1, 8'hA5);
    send_byte("lk_b", 4'b1101, 4'b1011, 4'b0100, 3'd2, 8'h33);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      req_valid = 4'b1001;
      #1 check($sformatf("lk_hold%0d", c), 32'(req_ready), 32'h0);
    end
    send_byte("lk_c", 4'b1101, 4'b1011, 4'b0100, 3'd2, 8'h33);
    send_byte("lk_d", 4'b1101, 4'b1111, 4'b0100, 3'd2, 8'h33);
    send_byte("lk_e", 4'b1101, 4'b1111, 4'b1000, 3'd3, 8'h44);
`else
    // no lock: consecutive bytes rotate even without end-of-packet
    send_byte("rr_a", 4'b0010, 4'b0000, 4'b0010, 3'd1, 8'hA5);
    send_byte("rr_b", 4'b1101, 4'b0000, 4'b0100, 3'd2, 8'h33);
    send_byte("rr_c", 4'b1101, 4'b0000, 4'b1000, 3'd3, 8'h44);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
